axi_write_slave: RTL and testbench

- AXI4 write-channel responder (AW, W, B) terminating a master's write bursts into an internal word-addressed memory.
- Used as the bench's target endpoint and as a reusable write-only slave behind the interconnect.
- Supports FIXED/INCR/WRAP bursts and byte strobes, with one outstanding transaction.
- Exposes a side read port so the scoreboard can inspect memory contents.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_burst_addr_gen.sv | 22 ++
 rtl/axi_write_slave.sv | 148 ++++++++++++++
 tb/tb_axi_write_slave.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst types, response codes and address helpers
package axi_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} wr_state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    // byte mask of the (len+1)<<size wrap window
    function automatic logic [31:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
        return ((32'(len) + 32'd1) << size) - 32'd1;
    endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat byte address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_size,
    input  logic [7:0]            i_len,
    input  burst_t                i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);
    logic [ADDR_WIDTH-1:0] w_step, w_incr, w_mask;
    assign w_step = ADDR_WIDTH'(1) << i_size;
    assign w_incr = (i_addr & ~(w_step - ADDR_WIDTH'(1))) + w_step;
    assign w_mask = ADDR_WIDTH'(wrap_mask(i_len, i_size));
    always_comb begin
        o_next_addr = i_addr;
        o_next_addr = i_burst == BURST_INCR ? w_incr :
                      i_burst == BURST_WRAP ? (i_addr & ~w_mask) | (w_incr & w_mask) : i_addr;
    end
endmodule

// File: rtl/axi_write_slave.sv
// axi_write_slave: AXI4 write-only slave (AW/W/B) into a word-addressed memory,
// one outstanding burst, with a side read port for inspection.
module axi_write_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int ID_WIDTH   = AXI_ID_W,
    parameter int MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ID_WIDTH-1:0]          awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_WIDTH-1:0]          bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0]        mem_rdata
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SB         = $clog2(STRB_WIDTH);
    localparam int IW         = $clog2(MEM_DEPTH);
    localparam int MEM_BYTES  = MEM_DEPTH * STRB_WIDTH;

    wr_state_t             r_state, w_next;
    logic [ID_WIDTH-1:0]   r_id, r_bid;
    logic [ADDR_WIDTH-1:0] r_addr, w_next_addr, w_off;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    burst_t                r_burst;
    logic [1:0]            r_bresp;
    logic                  r_err, r_awready, r_wready, r_bvalid;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [IW-1:0]         w_idx;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_end, w_in_range, w_aw_err, w_beat_err;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    assign w_aw_hs    = awvalid && r_awready;
    assign w_w_hs     = wvalid && r_wready;
    assign w_b_hs     = bready && r_bvalid;
    assign w_end      = wlast || r_cnt == r_len;
    // addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = w_off < ADDR_WIDTH'(MEM_BYTES);
    assign w_idx      = IW'(w_off >> SB);
    assign w_beat_err = !w_in_range || (w_end && (wlast != (r_cnt == r_len)));
    assign w_aw_err   = awsize > 3'(SB) || awburst == BURST_RSVD ||
                        (awburst == BURST_WRAP && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                        (awburst == BURST_WRAP &&
                         (awaddr & ((ADDR_WIDTH'(1) << awsize) - ADDR_WIDTH'(1))) != '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE && w_aw_hs) w_next = ST_DATA;
        else if (r_state == ST_DATA && w_w_hs && w_end) w_next = ST_RESP;
        else if (r_state == ST_RESP && w_b_hs) w_next = ST_IDLE;
    end

    // handshake outputs are decoded from the next state so they leave flops
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= w_next == ST_IDLE;
            r_wready  <= w_next == ST_DATA;
            r_bvalid  <= w_next == ST_RESP;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= BURST_FIXED;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_bid   <= '0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_id    <= awid;
                r_addr  <= awaddr;
                r_len   <= awlen;
                r_size  <= awsize;
                r_burst <= burst_t'(awburst);
                r_cnt   <= '0;
                r_err   <= w_aw_err;
            end
            if (w_w_hs) begin
                r_addr <= w_next_addr;
                r_cnt  <= r_cnt + 8'd1;
                r_err  <= r_err | w_beat_err;
                if (w_end) begin
                    r_bid   <= r_id;
                    r_bresp <= (r_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_w_hs && !r_err && w_in_range)
            for (int b = 0; b < STRB_WIDTH; b++)
                if (wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_rdata <= '0;
        else        r_rdata <= r_mem[mem_raddr];
    end

    assign awready   = r_awready;
    assign wready    = r_wready;
    assign bvalid    = r_bvalid;
    assign bid       = r_bid;
    assign bresp     = r_bresp;
    assign mem_rdata = r_rdata;
endmodule

// File: tb/tb_axi_write_slave.sv
// tb_axi_write_slave: randomized and directed bursts against a byte-level memory model
module tb_axi_write_slave;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  mem_raddr = '0;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [256];
    logic [31:0] snap  [256];
    logic [31:0] bdata [256];
    logic [3:0]  bstrb [256];

    axi_write_slave dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Memory effect of one burst, straight from the burst rules; returns expected bresp.
    function automatic logic [1:0] model_burst(input logic [31:0] addr, input int len, input int size,
                                               input int burst, input int wlast_at);
        longint bytes, total, base, a;
        int n;
        bit err;
        bytes = 64'd1 << size;
        total = (len + 1) * bytes;
        err = size > 2 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15})) ||
              (burst == 2 && (longint'(addr) % bytes) != 0);
        n = (wlast_at >= 0 && wlast_at < len) ? wlast_at + 1 : len + 1;
        base = (longint'(addr) / total) * total;
        for (int i = 0; i < n; i++) begin
            if (burst == 0) a = addr;
            else if (burst == 1) a = (i == 0) ? longint'(addr) : (longint'(addr) / bytes) * bytes + i * bytes;
            else a = base + (longint'(addr) - base + i * bytes) % total;
            if (a >= 1024) err = 1;
            else if (!err)
                for (int b = 0; b < 4; b++)
                    if (bstrb[i][b]) model[a / 4][8*b +: 8] = bdata[i][8*b +: 8];
        end
        if (wlast_at != len) err = 1;
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                            input int burst, input int wlast_at, input int hold,
                            output logic [1:0] resp, output logic [3:0] rbid, output int lat,
                            output bit hs_ok, output logic [1:0] exp);
        int n, t;
        n = (wlast_at >= 0 && wlast_at < len) ? wlast_at + 1 : len + 1;
        @(negedge aclk);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        if (!awready) begin checks++; errors++; $display("FAIL aw_timeout: awready=%b expected 1", awready); end
        @(negedge aclk);
        awvalid = 1'b0;
        lat = 1;
        while (!wready && lat < 50) begin @(negedge aclk); lat++; end
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
            wvalid = 1'b1; wdata = bdata[i]; wstrb = bstrb[i]; wlast = (i == wlast_at);
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            if (!wready) begin checks++; errors++; $display("FAIL w_timeout: wready=%b expected 1", wready); end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        if (!bvalid) begin checks++; errors++; $display("FAIL b_timeout: bvalid=%b expected 1", bvalid); end
        resp = bresp; rbid = bid; hs_ok = 1'b1;
        repeat (hold) begin
            @(negedge aclk);
            if (!(bvalid === 1'b1 && bid === rbid && bresp === resp && awready === 1'b0 && wready === 1'b0))
                hs_ok = 1'b0;
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        if (bvalid !== 1'b0 || awready !== 1'b1) hs_ok = 1'b0;
        exp = model_burst(addr, len, size, burst, wlast_at);
    endtask

    task automatic read_word(input int idx, output logic [31:0] d);
        @(negedge aclk);
        mem_raddr = 8'(idx);
        @(negedge aclk);
        d = mem_rdata;
    endtask

    task automatic dump_mem();
        for (int i = 0; i < 256; i++) read_word(i, snap[i]);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        checks++; if ({awready, wready, bvalid} !== 3'b000) begin errors++; $display("FAIL reset_hs: got %b expected 000", {awready, wready, bvalid}); end
        checks++; if (bid !== 4'h0) begin errors++; $display("FAIL reset_bid: got %h expected 0", bid); end
        checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp: got %b expected 00", bresp); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
        areset = 1'b0;
        @(negedge aclk);
        checks++; if ({awready, wready, bvalid} !== 3'b100) begin errors++; $display("FAIL reset_release: got %b expected 100", {awready, wready, bvalid}); end
    endtask

    task automatic test_fill();
        logic [1:0] resp, exp; logic [3:0] rbid; int lat, bad; bit hs_ok;
        for (int i = 0; i < 256; i++) begin bdata[i] = $urandom; bstrb[i] = 4'hF; end
        do_burst(4'h3, 32'h0, 255, 2, 1, 255, 0, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== exp) begin errors++; $display("FAIL fill_bresp: got %b expected %b", resp, exp); end
        checks++; if (rbid !== 4'h3) begin errors++; $display("FAIL fill_bid: got %h expected 3", rbid); end
        dump_mem(); bad = 0;
        for (int i = 0; i < 256; i++) if (snap[i] !== model[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_mem: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_incr();
        logic [1:0] resp, exp; logic [3:0] rbid; int lat, bad; bit hs_ok;
        for (int i = 0; i < 4; i++) begin bdata[i] = 32'(i + 1); bstrb[i] = 4'hF; end
        do_burst(4'h5, 32'h10, 3, 2, 1, 3, 0, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b expected 00", resp); end
        checks++; if (rbid !== 4'h5) begin errors++; $display("FAIL incr_bid: got %h expected 5", rbid); end
        checks++; if (lat != 1) begin errors++; $display("FAIL incr_wready_lat: got %0d expected 1", lat); end
        checks++; if (!hs_ok) begin errors++; $display("FAIL incr_b_handshake: got %b expected 1", hs_ok); end
        dump_mem(); bad = 0;
        for (int i = 0; i < 4; i++) if (snap[4 + i] !== 32'(i + 1)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL incr_words: %0d of words 4..7 wrong, expected 0", bad); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (snap[i] !== model[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL incr_mem: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_wrap();
        logic [1:0] resp, exp; logic [3:0] rbid; int lat, bad; bit hs_ok; logic [31:0] d;
        logic [31:0] dv [4];
        for (int i = 0; i < 4; i++) begin bdata[i] = $urandom; bstrb[i] = 4'hF; dv[i] = bdata[i]; end
        do_burst(4'h6, 32'h38, 3, 2, 2, 3, 1, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp: got %b expected 00", resp); end
        read_word(14, d); checks++; if (d !== dv[0]) begin errors++; $display("FAIL wrap_0x38: got %h expected %h", d, dv[0]); end
        read_word(15, d); checks++; if (d !== dv[1]) begin errors++; $display("FAIL wrap_0x3C: got %h expected %h", d, dv[1]); end
        read_word(12, d); checks++; if (d !== dv[2]) begin errors++; $display("FAIL wrap_0x30: got %h expected %h", d, dv[2]); end
        read_word(13, d); checks++; if (d !== dv[3]) begin errors++; $display("FAIL wrap_0x34: got %h expected %h", d, dv[3]); end
        for (int i = 0; i < 3; i++) bdata[i] = $urandom;
        do_burst(4'h7, 32'h40, 2, 2, 2, 2, 0, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wrap_badlen_bresp: got %b expected 10", resp); end
        dump_mem(); bad = 0;
        for (int i = 0; i < 256; i++) if (snap[i] !== model[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_mem: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_fixed();
        logic [1:0] resp, exp; logic [3:0] rbid; int lat; bit hs_ok; logic [31:0] d;
        bdata[0] = 32'hAAAA_1111; bstrb[0] = 4'h3;
        bdata[1] = 32'hBBBB_2222; bstrb[1] = 4'hC;
        do_burst(4'h8, 32'h20, 1, 2, 0, 1, 0, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp: got %b expected 00", resp); end
        read_word(8, d);
        checks++; if (d !== 32'hBBBB_1111) begin errors++; $display("FAIL fixed_word8: got %h expected bbbb1111", d); end
    endtask

    task automatic test_oob();
        logic [1:0] resp, exp; logic [3:0] rbid; int lat, bad; bit hs_ok; logic [31:0] d;
        logic [31:0] d0, d1;
        for (int i = 0; i < 4; i++) begin bdata[i] = $urandom; bstrb[i] = 4'hF; end
        d0 = bdata[0]; d1 = bdata[1];
        do_burst(4'h9, 32'h3F8, 3, 2, 1, 3, 0, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oob_bresp: got %b expected 10", resp); end
        read_word(254, d); checks++; if (d !== d0) begin errors++; $display("FAIL oob_w254: got %h expected %h", d, d0); end
        read_word(255, d); checks++; if (d !== d1) begin errors++; $display("FAIL oob_w255: got %h expected %h", d, d1); end
        dump_mem(); bad = 0;
        for (int i = 0; i < 256; i++) if (snap[i] !== model[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL oob_mem: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_wlast_err();
        logic [1:0] resp, exp; logic [3:0] rbid; int lat; bit hs_ok;
        for (int i = 0; i < 4; i++) begin bdata[i] = $urandom; bstrb[i] = 4'hF; end
        do_burst(4'hA, 32'h80, 3, 2, 1, 1, 5, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp: got %b expected 10", resp); end
        checks++; if (rbid !== 4'hA) begin errors++; $display("FAIL early_wlast_bid: got %h expected a", rbid); end
        checks++; if (!hs_ok) begin errors++; $display("FAIL bready_stall_stable: got %b expected 1", hs_ok); end
        do_burst(4'hB, 32'h90, 2, 2, 1, -1, 0, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL missing_wlast_bresp: got %b expected 10", resp); end
    endtask

    task automatic test_random();
        logic [1:0] resp, exp; logic [3:0] rbid, id; int lat, bad, burst, size, len, wl; bit hs_ok;
        logic [31:0] addr;
        int wlens [5] = '{1, 2, 3, 7, 15};
        for (int k = 0; k < 12; k++) begin
            burst = $urandom_range(0, 3);
            size = $urandom_range(0, 3);
            len = (burst == 2) ? wlens[$urandom_range(0, 4)] : $urandom_range(0, 15);
            addr = $urandom_range(0, 'h4FF);
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << size) - 32'd1);
            wl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
            id = 4'($urandom);
            for (int i = 0; i <= len; i++) begin bdata[i] = $urandom; bstrb[i] = 4'($urandom); end
            do_burst(id, addr, len, size, burst, wl, $urandom_range(0, 3), resp, rbid, lat, hs_ok, exp);
            checks++; if (resp !== exp) begin errors++; $display("FAIL rand%0d_bresp: got %b expected %b (burst=%0d size=%0d len=%0d addr=%h)", k, resp, exp, burst, size, len, addr); end
            checks++; if (rbid !== id) begin errors++; $display("FAIL rand%0d_bid: got %h expected %h", k, rbid, id); end
            checks++; if (lat != 1 || !hs_ok) begin errors++; $display("FAIL rand%0d_timing: lat=%0d hs_ok=%b expected 1/1", k, lat, hs_ok); end
        end
        dump_mem(); bad = 0;
        for (int i = 0; i < 256; i++) if (snap[i] !== model[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_mem: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp, exp; logic [3:0] rbid; int lat, bad, t; bit hs_ok;
        for (int i = 0; i < 4; i++) begin bdata[i] = $urandom; bstrb[i] = 4'hF; end
        @(negedge aclk);
        mem_raddr = 8'd64;
        awvalid = 1'b1; awid = 4'hC; awaddr = 32'h100; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = bdata[i]; wstrb = 4'hF; wlast = 1'b0;
            checks++; if (wready !== 1'b1) begin errors++; $display("FAIL midrst_wready%0d: got %b expected 1", i, wready); end
            @(negedge aclk);
        end
        wvalid = 1'b0;
        model[64] = bdata[0]; model[65] = bdata[1];
        areset = 1'b1;
        #1;
        checks++; if ({awready, wready, bvalid, bid, bresp} !== 9'h0) begin errors++; $display("FAIL midrst_outputs: got %b expected 0", {awready, wready, bvalid, bid, bresp}); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", mem_rdata); end
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL midrst_awready: got %b expected 1", awready); end
        for (int i = 0; i < 4; i++) begin bdata[i] = $urandom; bstrb[i] = 4'hF; end
        do_burst(4'hD, 32'h200, 3, 2, 1, 3, 0, resp, rbid, lat, hs_ok, exp);
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL midrst_new_bresp: got %b expected 00", resp); end
        dump_mem(); bad = 0;
        for (int i = 0; i < 256; i++) if (snap[i] !== model[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_mem: %0d words differ, expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_incr();
        test_wrap();
        test_fixed();
        test_oob();
        test_wlast_err();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
